// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: result-source encodings, load funct3 codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package wb_pkg;

    // Result-source select values carried on mtr; 5..7 are reserved and write zero.
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MEM = 1;
    localparam int WB_SRC_PC4 = 2;
    localparam int WB_SRC_IMM = 3;
    localparam int WB_SRC_CSR = 4;

    // Load-type encodings (RISC-V funct3 for loads).
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_load_ext.sv
// Load alignment and sign/zero extension of a raw data-memory word.
// Latency: combinational.
// Backpressure: none.
// Ports: rdata (raw word), funct3 (load type), addr_lo (byte offset) -> ext_data (XLEN result).
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] ext_data
);

    logic [XLEN-1:0] byte_shift;
    logic [XLEN-1:0] half_shift;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;

    // Bytes are picked by the full offset; halves only by offset bit 1,
    // so a misaligned halfword reads the enclosing aligned half.
    assign byte_shift = rdata >> {addr_lo, 3'b000};
    assign half_shift = rdata >> {addr_lo[1], 4'b0000};
    assign byte_v     = byte_shift[7:0];
    assign half_v     = half_shift[15:0];

    always_comb begin
        case (funct3)
            LD_LB:   ext_data = XLEN'($signed(byte_v));
            LD_LH:   ext_data = XLEN'($signed(half_v));
            LD_LBU:  ext_data = XLEN'(byte_v);
            LD_LHU:  ext_data = XLEN'(half_v);
            // LW and every undefined encoding: low word, sign-extended on RV64.
            default: ext_data = XLEN'($signed(rdata[31:0]));
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: selects the result source, extends load data, writes the register file.
// Latency: 1 cycle from accept (or from dmem_rvalid for a waited load) to the rf_we pulse.
// Backpressure: in_ready drops while a load waits for its memory response (WAIT_MEM).
// Ports: in_valid/in_ready handshake; mtr, alu_result, pc4, imm_in, csr_rdata, rd, reg_we,
//        ld_funct3, addr_lo from memory stage; dmem_rvalid/dmem_rdata from data memory;
//        rf_we/rf_rd/rf_wdata to register file; busy; instret when WB_INSTRET_EN is defined.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] mtr,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  pc4,
    input  logic [XLEN-1:0]  imm_in,
    input  logic [XLEN-1:0]  csr_rdata,
    input  logic [4:0]       rd,
    input  logic             reg_we,
    input  logic [2:0]       ld_funct3,
    input  logic [1:0]       addr_lo,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             busy
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]      instret
`endif
);

    wb_state_t       state_q, state_d;
    logic [4:0]      lat_rd;
    logic            lat_we;
    logic [2:0]      lat_funct3;
    logic [1:0]      lat_addr_lo;

    logic            is_mem;
    logic            accept;
    logic            start_wait;
    logic            retire_direct;
    logic            retire_load;
    logic            retire;
    logic [2:0]      ext_funct3;
    logic [1:0]      ext_addr_lo;
    logic [XLEN-1:0] ext_data;
    logic [XLEN-1:0] src_data;
    logic            wr_we;
    logic [4:0]      wr_rd;

    assign in_ready      = (state_q == ST_IDLE);
    assign busy          = (state_q == ST_WAIT_MEM);
    assign is_mem        = (mtr == SEL_W'(WB_SRC_MEM));
    assign accept        = in_valid && in_ready;
    assign start_wait    = accept && is_mem && !dmem_rvalid;
    assign retire_direct = accept && (!is_mem || dmem_rvalid);
    // A response seen in IDLE without a MEM instruction never reaches here.
    assign retire_load   = busy && dmem_rvalid;
    assign retire        = retire_direct || retire_load;

    // While waiting, the live inputs belong to nobody; use the latched load fields.
    assign ext_funct3  = busy ? lat_funct3  : ld_funct3;
    assign ext_addr_lo = busy ? lat_addr_lo : addr_lo;
    assign wr_we       = busy ? lat_we      : reg_we;
    assign wr_rd       = busy ? lat_rd      : rd;

    wb_load_ext #(.XLEN(XLEN)) u_load_ext (
        .rdata    (dmem_rdata),
        .funct3   (ext_funct3),
        .addr_lo  (ext_addr_lo),
        .ext_data (ext_data)
    );

    always_comb begin
        src_data = '0;
        case (mtr)
            SEL_W'(WB_SRC_ALU): src_data = alu_result;
            SEL_W'(WB_SRC_MEM): src_data = ext_data;
            SEL_W'(WB_SRC_PC4): src_data = pc4;
            SEL_W'(WB_SRC_IMM): src_data = imm_in;
            SEL_W'(WB_SRC_CSR): src_data = csr_rdata;
            default:            src_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_wait) state_d = ST_WAIT_MEM;
            ST_WAIT_MEM: if (dmem_rvalid) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_rd      <= '0;
            lat_we      <= 1'b0;
            lat_funct3  <= '0;
            lat_addr_lo <= '0;
        end else if (start_wait) begin
            lat_rd      <= rd;
            lat_we      <= reg_we;
            lat_funct3  <= ld_funct3;
            lat_addr_lo <= addr_lo;
        end
    end

    // rf_we is a single-cycle pulse; address and data hold until the next retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= retire && wr_we && (wr_rd != 5'd0);
            if (retire) begin
                rf_rd    <= wr_rd;
                rf_wdata <= busy ? ext_data : src_data;
            end
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    // Counts retirements regardless of whether the register file is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered, handshaked writeback stage for the RISC-V core. It replaces the purely combinational writeback select with a clocked stage. The stage:
- selects the result source (ALU, load data, PC+4, immediate, CSR);
- aligns and sign/zero-extends load data;
- waits for variable-latency data-memory responses;
- issues a single-cycle register-file write.

It sits between the memory stage and the register file.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64)
- SEL_W, 3, width of the source-select field

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction presented for writeback
- in_ready  out  1  stage can accept an instruction this cycle
- mtr  in  SEL_W  source select: 0 ALU, 1 MEM, 2 PC4, 3 IMM, 4 CSR, 5–7 reserved
- alu_result, pc4, imm_in, csr_rdata  in  XLEN  candidate results
- rd  in  5  destination register
- reg_we  in  1  instruction writes rd
- ld_funct3  in  3  load type: LB 000, LH 001, LW 010, LBU 100, LHU 101
- addr_lo  in  2  byte offset of the load address
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  raw word from data memory
- rf_we  out  1  register-file write strobe
- rf_rd  out  5  write address
- rf_wdata  out  XLEN  write data
- busy  out  1  high while in WAIT_MEM
- instret  out  64  retired-instruction count (only with WB_INSTRET_EN)

## Operation
- FSM has two states, IDLE and WAIT_MEM. Reset state is IDLE.
- in_ready = (state == IDLE).
- IDLE, in_valid=1, mtr≠MEM:
  - register the selected source into rf_wdata;
  - rf_rd ← rd;
  - rf_we ← reg_we && rd≠0;
  - stay in IDLE.
- IDLE, in_valid=1, mtr=MEM, dmem_rvalid=1 in the same cycle (zero-wait memory): treat as a completed load immediately; stay in IDLE.
- IDLE, in_valid=1, mtr=MEM, dmem_rvalid=0:
  - latch rd, reg_we, ld_funct3 and addr_lo;
  - go to WAIT_MEM.
- WAIT_MEM, dmem_rvalid=1:
  - write the extended load data using the latched fields;
  - return to IDLE.
- WAIT_MEM, dmem_rvalid=0: hold state. busy=1 and in_ready=0.
- Load extension:
  - byte = dmem_rdata[8*addr_lo +: 8];
  - half = dmem_rdata[16*addr_lo[1] +: 16];
  - LB and LH sign-extend to XLEN;
  - LBU and LHU zero-extend;
  - LW passes bits [31:0], sign-extended when XLEN=64;
  - undefined funct3 encodings use LW behaviour.
- Reserved mtr values write 0 with rf_we governed by the normal rule. No error is flagged.
- rd=0 never asserts rf_we. rf_wdata is still updated.
- dmem_rvalid in IDLE without an accompanying MEM instruction is ignored.
- in_valid while in WAIT_MEM is not accepted (in_ready=0). The upstream stage must hold its inputs.

## Timing
- Reset values: state=IDLE, rf_we=0, rf_rd=0, rf_wdata=0, busy=0, instret=0. in_ready=1 once out of reset.
- Reset asserted during WAIT_MEM aborts the pending load. The response that follows reset is ignored.
- Latency: non-load, or load with same-cycle dmem_rvalid: rf_we is high in cycle N+1 for an accept in cycle N.
- Latency, waited load: rf_we is high in the cycle after dmem_rvalid.
- rf_we is a one-cycle pulse per retired instruction. rf_rd and rf_wdata hold their values until the next write.
- Throughput: one instruction per cycle when no load waits.

## Configuration
- WB_INSTRET_EN defined:
  - instret port exists;
  - 64-bit counter increments once per retired instruction (each non-MEM accept, each load completion), independent of rf_we;
  - wraps at 2^64−1 → 0.
- WB_INSTRET_EN undefined: no instret port and no counter logic.

## Structure
- Shared package wb_pkg holds:
  - the mtr source encodings (WB_SRC_ALU…WB_SRC_CSR);
  - the load funct3 constants;
  - the state enum.
- One sub-module, wb_load_ext: combinational alignment and extension, with inputs rdata, funct3, addr_lo and output ext_data.

## Test plan
- Non-load: mtr=0, alu_result=0x0000_1234, rd=5, reg_we=1 → next cycle rf_we=1, rf_rd=5, rf_wdata=0x0000_1234; one cycle later rf_we=0.
- rd=0: mtr=2, pc4=0x100, rd=0, reg_we=1 → rf_we stays 0; rf_wdata=0x100.
- Waited load: mtr=1, LB, addr_lo=3, rd=7; dmem_rvalid arrives 3 cycles later with rdata=0x80FF_FF7F → busy=1 and in_ready=0 for 3 cycles; then rf_wdata=0xFFFF_FF80, rf_we=1.
- Zero-wait load: LHU, addr_lo=2, same-cycle dmem_rvalid, rdata=0xBEEF_0000 → next cycle rf_wdata=0x0000_BEEF.
- Reset during WAIT_MEM: assert rst, then deliver dmem_rvalid → no rf_we; state is IDLE; in_ready=1.
- WB_INSTRET_EN: retire 10 instructions (3 of them waited loads) → instret=10; preload 2^64−1 and retire one more → instret=0.
